// File: rtl/serial_right_shifter_if.sv
// Handshake/data bundle for serial_right_shifter.
// SRS_LEFT_EN adds the 'left' direction select.
interface serial_right_shifter_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
);
   logic               start;
   logic [WIDTH-1:0]   d;
   logic [SHAMT_W-1:0] shamt;
   logic               arith;
`ifdef SRS_LEFT_EN
   logic               left;
`endif
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   o;

`ifdef SRS_LEFT_EN
   modport master (
      output start, d, shamt, arith, left,
      input  busy, done, o
   );

   modport slave (
      input  start, d, shamt, arith, left,
      output busy, done, o
   );
`else
   modport master (
      output start, d, shamt, arith,
      input  busy, done, o
   );

   modport slave (
      input  start, d, shamt, arith,
      output busy, done, o
   );
`endif
endinterface

// File: rtl/serial_right_shifter.sv
// Iterative one-bit-per-clock right shifter (logical/arithmetic) with start/busy/done.
// Define SRS_LEFT_EN to add a captured 'left' select for logical left shifts.
module serial_right_shifter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_right_shifter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   o_q;
   logic [WIDTH-1:0]   shifted;
   logic [SHAMT_W-1:0] cnt_q;
   logic               arith_q;
   logic               accept;
`ifdef SRS_LEFT_EN
   logic               left_q;
`endif

   assign accept = (state_q == IDLE) && bus.start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.shamt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The MSB of o_q still holds the captured sign, so it doubles as the fill bit.
   always_comb begin
      shifted = {(arith_q & o_q[WIDTH-1]), o_q[WIDTH-1:1]};
`ifdef SRS_LEFT_EN
      if (left_q) begin
         shifted = {o_q[WIDTH-2:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q     <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
`ifdef SRS_LEFT_EN
         left_q  <= 1'b0;
`endif
      end else if (accept) begin
         o_q     <= bus.d;
         cnt_q   <= bus.shamt;
         arith_q <= bus.arith;
`ifdef SRS_LEFT_EN
         left_q  <= bus.left;
`endif
      end else if (state_q == SHIFT) begin
         o_q   <= shifted;
         cnt_q <= cnt_q - SHAMT_W'(1);
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.o    = o_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed bench for serial_right_shifter with a per-cycle reference model
// and literal result/latency checks.
module tb_serial_right_shifter;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SHAMT_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;

   serial_right_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

   serial_right_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] v, input int n,
                                                  input bit ar, input bit lf);
      if (lf) return v << n;
      if (ar) return $unsigned($signed(v) >>> n);
      return v >> n;
   endfunction

   // Reference model: an operation accepted at edge k is busy after edges k..k+shamt,
   // done after edge k+shamt, and o equals d shifted by min(j, shamt) after edge k+j.
   int               edge_n = 0;
   bit               active = 1'b0;
   int               acc_edge = 0;
   int               acc_shamt = 0;
   logic [WIDTH-1:0] acc_d = '0;
   bit               acc_arith = 1'b0;
   bit               acc_left = 1'b0;
   bit               chk_en = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
      end else begin
         edge_n <= edge_n + 1;
         if ((!active || edge_n >= acc_edge + acc_shamt + 2) && bus.start === 1'b1) begin
            active    <= 1'b1;
            acc_edge  <= edge_n;
            acc_shamt <= int'(bus.shamt);
            acc_d     <= bus.d;
            acc_arith <= bus.arith;
`ifdef SRS_LEFT_EN
            acc_left  <= bus.left;
`else
            acc_left  <= 1'b0;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (!active) begin
            check("model_busy", WIDTH'(bus.busy), '0);
            check("model_done", WIDTH'(bus.done), '0);
            check("model_o", bus.o, '0);
         end else begin
            int j;
            int k;
            j = edge_n - 1 - acc_edge;
            k = (j > acc_shamt) ? acc_shamt : j;
            check("model_busy", WIDTH'(bus.busy), WIDTH'(j <= acc_shamt));
            check("model_done", WIDTH'(bus.done), WIDTH'(j == acc_shamt));
            check("model_o", bus.o, ref_shift(acc_d, k, acc_arith, acc_left));
         end
      end
   end

   task automatic set_in(input logic [WIDTH-1:0] dv, input int sh, input bit ar, input bit lf);
      bus.d     = dv;
      bus.shamt = SHAMT_W'(sh);
      bus.arith = ar;
`ifdef SRS_LEFT_EN
      bus.left  = lf;
`else
      if (lf) $display("left shift requested without SRS_LEFT_EN");
`endif
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_done: got timeout want done within 40 cycles");
      end
   endtask

   // One operation: start for a single cycle, then check latency and final result.
   task automatic run_op(input string name, input logic [WIDTH-1:0] dv, input int sh,
                         input bit ar, input bit lf, input logic [WIDTH-1:0] exp);
      int lat;
      @(negedge clk);
      set_in(dv, sh, ar, lf);
      bus.start = 1'b1;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({name, "_lat"}, WIDTH'(lat), WIDTH'(sh));
      check({name, "_o"}, bus.o, exp);
   endtask

   initial begin
      int lat;
      bus.start = 1'b0;
      set_in('0, 0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("reset_busy", WIDTH'(bus.busy), '0);
      check("reset_done", WIDTH'(bus.done), '0);
      check("reset_o", bus.o, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      run_op("lsr4",     32'h8000_0000, 4,  1'b0, 1'b0, 32'h0800_0000);
      run_op("asr4",     32'h8000_0000, 4,  1'b1, 1'b0, 32'hF800_0000);
      run_op("asr31",    32'h8000_0000, 31, 1'b1, 1'b0, 32'hFFFF_FFFF);
      run_op("lsr31",    32'h8000_0000, 31, 1'b0, 1'b0, 32'h0000_0001);
      run_op("sh0",      32'h1234_5678, 0,  1'b0, 1'b0, 32'h1234_5678);
      run_op("asr_pos",  32'h7000_00F0, 4,  1'b1, 1'b0, 32'h0700_000F);
      run_op("asr_neg1", 32'hC000_0003, 1,  1'b1, 1'b0, 32'hE000_0001);

      // Start held high across an operation: the changed operands wait for IDLE.
      @(negedge clk);
      set_in(32'h8000_0000, 4, 1'b0, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      set_in(32'hDEAD_BEEF, 3, 1'b0, 1'b0);
      wait_done(lat);
      check("hold_first_lat", WIDTH'(lat), WIDTH'(3));
      check("hold_first_o", bus.o, 32'h0800_0000);
      @(negedge clk);
      check("hold_idle_o", bus.o, 32'h0800_0000);
      check("hold_idle_busy", WIDTH'(bus.busy), '0);
      @(negedge clk);
      bus.start = 1'b0;
      check("hold_second_cap", bus.o, 32'hDEAD_BEEF);
      wait_done(lat);
      check("hold_second_lat", WIDTH'(lat), WIDTH'(2));
      check("hold_second_o", bus.o, 32'h1BD5_B7DD);

`ifdef SRS_LEFT_EN
      run_op("lsl31", 32'h0000_0001, 31, 1'b1, 1'b1, 32'h8000_0000);
      run_op("lsl4",  32'h0000_00F1, 4,  1'b0, 1'b1, 32'h0000_0F10);
`endif

      // Asynchronous reset in the middle of a long shift.
      @(negedge clk);
      set_in(32'hFFFF_0000, 20, 1'b0, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", WIDTH'(bus.busy), WIDTH'(1));
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", WIDTH'(bus.busy), '0);
      check("async_rst_done", WIDTH'(bus.done), '0);
      check("async_rst_o", bus.o, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_o", bus.o, '0);

      run_op("after_rst", 32'h0000_00FF, 2, 1'b0, 1'b0, 32'h0000_003F);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule
